alu_seq: RTL and testbench

- Execution stage directly downstream of the register file in the 8-bit CPU datapath.
- Consumes the two register-file read ports (reg_1_out, reg_2_out) as operands a and b.
- Performs single-cycle logic/arith ops and a multi-cycle shift-add multiply, under a start/busy/done handshake.
- Produces a registered result, driven back to the register file's reg_data_in, and a registered flags word for the control unit.

---
 rtl/alu_seq.sv | 210 +++++++++++++++++++++
 tb/tb_alu_seq.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: execution stage behind the register file. It runs the single-cycle
// logic and arithmetic ops, plus a shift-add multiply that takes several cycles,
// under a start/busy/done handshake. The result and the flags are registered.
// Build option: define ALU_SEQ_MUL_EN to include the multiplier (opcode 8).
// When the macro is undefined, opcode 8 is treated as an illegal opcode.
module alu_seq #(
  parameter int DATA_BUS_WIDTH = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic [3:0]                alu_op,
  input  logic [DATA_BUS_WIDTH-1:0] operand_a,
  input  logic [DATA_BUS_WIDTH-1:0] operand_b,
  output logic [DATA_BUS_WIDTH-1:0] result,
  output logic [3:0]                flags,
  output logic                      busy,
  output logic                      done,
  output logic                      illegal_op
);

  localparam int W = DATA_BUS_WIDTH;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;
  localparam logic [3:0] OP_CMP = 4'd9;

  logic [W-1:0] result_q, result_d;
  logic [3:0]   flags_q, flags_d;
  logic         done_q, done_d;
  logic         ill_q, ill_d;

  // Single-cycle datapath. It works straight from the operands present at the start edge.
  logic [W:0]   add_w, sub_w;
  logic [W-1:0] alu_r;
  logic         alu_c, alu_v, alu_wr, alu_ill;

  // Evaluate the single-cycle op and its C/V flags.
  // CMP computes SUB's flags but does not write the result register.
  always_comb begin
    add_w   = {1'b0, operand_a} + {1'b0, operand_b};
    sub_w   = {1'b0, operand_a} - {1'b0, operand_b};
    alu_r   = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_wr  = 1'b1;
    alu_ill = 1'b0;
    case (alu_op)
      OP_ADD: begin
        alu_r = add_w[W-1:0];
        alu_c = add_w[W];
        alu_v = (operand_a[W-1] == operand_b[W-1]) && (add_w[W-1] != operand_a[W-1]);
      end
      OP_SUB, OP_CMP: begin
        alu_r  = sub_w[W-1:0];
        alu_c  = sub_w[W];                // borrow, i.e. a < b unsigned
        alu_v  = (operand_a[W-1] != operand_b[W-1]) && (sub_w[W-1] != operand_a[W-1]);
        alu_wr = (alu_op != OP_CMP);
      end
      OP_AND: alu_r = operand_a & operand_b;
      OP_OR:  alu_r = operand_a | operand_b;
      OP_XOR: alu_r = operand_a ^ operand_b;
      OP_NOT: alu_r = ~operand_a;
      OP_SHL: begin
        alu_r = {operand_a[W-2:0], 1'b0};
        alu_c = operand_a[W-1];
      end
      OP_SHR: begin
        alu_r = {1'b0, operand_a[W-1:1]};
        alu_c = operand_a[0];
      end
      default: alu_ill = 1'b1;            // 10-15, and 8 when there is no multiplier
    endcase
  end

`ifdef ALU_SEQ_MUL_EN
  localparam int          CW     = $clog2(W + 1);
  localparam logic [3:0]  OP_MUL = 4'd8;

  typedef enum logic {IDLE, MUL_RUN} state_t;

  state_t          state_q, state_d;
  logic [2*W-1:0]  acc_q, acc_d;
  logic [W-1:0]    mcand_q, mcand_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic [W:0]      psum;
  logic [2*W-1:0]  acc_step;

  // One shift-add step. The upper half accumulates the multiplicand, and the
  // multiplier bits are shifted out of the lower half.
  // The carry out of the add is folded back into the top bit of the shifted accumulator.
  always_comb begin
    psum     = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    acc_step = {psum, acc_q[W-1:1]};
  end

  // Next-state logic for the FSM, the multiplier and the output registers.
  always_comb begin
    result_d = result_q;
    flags_d  = flags_q;
    done_d   = 1'b0;
    ill_d    = 1'b0;
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (alu_op == OP_MUL) begin
            state_d = MUL_RUN;
            acc_d   = {{W{1'b0}}, operand_b};
            mcand_d = operand_a;
            cnt_d   = CW'(W);
          end else begin
            done_d = 1'b1;
            if (alu_ill) begin
              result_d = '0;
              ill_d    = 1'b1;
            end else begin
              if (alu_wr) result_d = alu_r;
              flags_d = {(alu_r == '0), alu_r[W-1], alu_c, alu_v};
            end
          end
        end
      end
      MUL_RUN: begin
        acc_d = acc_step;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d  = IDLE;
          done_d   = 1'b1;
          result_d = acc_step[W-1:0];
          flags_d  = {(acc_step[W-1:0] == '0), acc_step[W-1],
                      (acc_step[2*W-1:W] != '0), 1'b0};
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == MUL_RUN);
  end

  // Multiplier state. It clears at once on reset, which drops any op in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  assign busy = busy_q;
`else
  // Next values of the output registers. Every accepted op completes in one cycle.
  always_comb begin
    result_d = result_q;
    flags_d  = flags_q;
    done_d   = 1'b0;
    ill_d    = 1'b0;
    if (start) begin
      done_d = 1'b1;
      if (alu_ill) begin
        result_d = '0;
        ill_d    = 1'b1;
      end else begin
        if (alu_wr) result_d = alu_r;
        flags_d = {(alu_r == '0), alu_r[W-1], alu_c, alu_v};
      end
    end
  end

  assign busy = 1'b0;
`endif

  // Output registers. done and illegal_op default low, so they only ever pulse.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      result_q <= '0;
      flags_q  <= '0;
      done_q   <= 1'b0;
      ill_q    <= 1'b0;
    end else begin
      result_q <= result_d;
      flags_q  <= flags_d;
      done_q   <= done_d;
      ill_q    <= ill_d;
    end
  end

  assign result     = result_q;
  assign flags      = flags_q;
  assign done       = done_q;
  assign illegal_op = ill_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (W=8). It runs a table of single-cycle ops back to back,
// then hand-written sequences for async reset, illegal opcodes and the multiply.
module tb_alu_seq;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] alu_op;
  logic [7:0] operand_a, operand_b;
  logic [7:0] result;
  logic [3:0] flags;
  logic       busy, done, illegal_op;

  int total = 0;
  int bad   = 0;

  alu_seq #(.DATA_BUS_WIDTH(8)) dut (
    .clock(clock), .reset(reset), .start(start), .alu_op(alu_op),
    .operand_a(operand_a), .operand_b(operand_b), .result(result),
    .flags(flags), .busy(busy), .done(done), .illegal_op(illegal_op)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic [3:0] flg;   // {Z,N,C,V}
    logic       ill;
  } vec_t;

  vec_t vt[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Start one op at a negedge, then check the completion at the negedge of cycle 1.
  // start is left high; the caller clears it or starts the next op.
  task automatic single(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] er, input logic [3:0] ef, input logic eill,
                        input string name);
    start = 1'b1; alu_op = op; operand_a = a; operand_b = b;
    @(posedge clock);
    @(negedge clock);
    chk({name, ".done"}, done, 1);
    chk({name, ".ill"}, illegal_op, eill);
    chk({name, ".busy"}, busy, 0);
    chk({name, ".res"}, result, er);
    chk({name, ".flags"}, flags, ef);
  endtask

`ifdef ALU_SEQ_MUL_EN
  // Multiply: busy must be high in cycles 1..8 and done must pulse only in cycle 9.
  // With ign set, a start for an ADD is pulsed in cycle 3. It must be ignored.
  task automatic run_mul(input logic [7:0] a, input logic [7:0] b, input logic [7:0] er,
                         input logic [3:0] ef, input bit ign, input string name);
    int dcnt;
    dcnt = 0;
    start = 1'b1; alu_op = 4'd8; operand_a = a; operand_b = b;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0; operand_a = 8'h00; operand_b = 8'h00;
    for (int c = 1; c <= 8; c++) begin
      if (busy !== 1'b1) begin bad++; $display("FAIL %s.busy cyc%0d: got %0b expected 1", name, c, busy); end
      if (done) dcnt++;
      if (ign && c == 3) begin start = 1'b1; alu_op = 4'd0; operand_a = 8'h01; operand_b = 8'h01; end
      else start = 1'b0;
      @(negedge clock);
    end
    start = 1'b0;
    total++;
    chk({name, ".done"}, done, 1);
    chk({name, ".busy_end"}, busy, 0);
    chk({name, ".res"}, result, er);
    chk({name, ".flags"}, flags, ef);
    @(negedge clock);
    chk({name, ".done_once"}, done, 0);
    chk({name, ".res_hold"}, result, er);
    chk({name, ".early_done"}, dcnt, 0);
  endtask
`endif

  initial begin
    // Table entries are in order, so each row sees the state left by the rows before it.
    vt[0]  = '{4'd0, 8'hFF, 8'h01, 8'h00, 4'b1010, 1'b0}; // ADD carry, zero
    vt[1]  = '{4'd1, 8'h80, 8'h01, 8'h7F, 4'b0001, 1'b0}; // SUB overflow
    vt[2]  = '{4'd9, 8'h05, 8'h05, 8'h7F, 4'b1000, 1'b0}; // CMP equal, result held
    vt[3]  = '{4'd0, 8'h7F, 8'h01, 8'h80, 4'b0101, 1'b0}; // ADD overflow
    vt[4]  = '{4'd1, 8'h01, 8'h02, 8'hFF, 4'b0110, 1'b0}; // SUB borrow
    vt[5]  = '{4'd2, 8'hF0, 8'h3C, 8'h30, 4'b0000, 1'b0}; // AND
    vt[6]  = '{4'd3, 8'h0F, 8'hF0, 8'hFF, 4'b0100, 1'b0}; // OR
    vt[7]  = '{4'd4, 8'hAA, 8'hAA, 8'h00, 4'b1000, 1'b0}; // XOR
    vt[8]  = '{4'd5, 8'h55, 8'h00, 8'hAA, 4'b0100, 1'b0}; // NOT
    vt[9]  = '{4'd6, 8'h81, 8'h00, 8'h02, 4'b0010, 1'b0}; // SHL
    vt[10] = '{4'd7, 8'h81, 8'h00, 8'h40, 4'b0010, 1'b0}; // SHR
    vt[11] = '{4'd7, 8'h02, 8'h00, 8'h01, 4'b0000, 1'b0}; // SHR
    vt[12] = '{4'd9, 8'h03, 8'h05, 8'h01, 4'b0110, 1'b0}; // CMP less
    vt[13] = '{4'hA, 8'h12, 8'h34, 8'h00, 4'b0110, 1'b1}; // illegal
    vt[14] = '{4'hF, 8'h12, 8'h34, 8'h00, 4'b0110, 1'b1}; // illegal
    vt[15] = '{4'd0, 8'h40, 8'h40, 8'h80, 4'b0101, 1'b0}; // ADD overflow

    reset = 1'b0; start = 1'b0; alu_op = 4'd0; operand_a = 8'h00; operand_b = 8'h00;
    @(negedge clock);
    chk("rst.res", result, 0);
    chk("rst.flags", flags, 0);
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.ill", illegal_op, 0);
    reset = 1'b1;
    @(negedge clock);

    // Back-to-back single-cycle ops, one start per cycle
    for (int i = 0; i < 16; i++)
      single(vt[i].op, vt[i].a, vt[i].b, vt[i].res, vt[i].flg, vt[i].ill, $sformatf("vec%0d", i));
    start = 1'b0;
    @(negedge clock);
    chk("pulse.done", done, 0);
    chk("pulse.ill", illegal_op, 0);
    chk("pulse.res_hold", result, 8'h80);

    // Async reset asserted mid-cycle must clear the outputs before any clock edge
    #2 reset = 1'b0;
    #1;
    chk("arst.res", result, 0);
    chk("arst.flags", flags, 0);
    chk("arst.busy", busy, 0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    single(4'd6, 8'h81, 8'h00, 8'h02, 4'b0010, 1'b0, "shl_after_rst");
    start = 1'b0;
    @(negedge clock);

`ifdef ALU_SEQ_MUL_EN
    run_mul(8'd13, 8'd11, 8'h8F, 4'b0100, 1'b0, "mul13x11");
    run_mul(8'd20, 8'd20, 8'h90, 4'b0110, 1'b0, "mul20x20");
    run_mul(8'd13, 8'd11, 8'h8F, 4'b0100, 1'b1, "mul_ign");
    // Reset in cycle 4 of a multiply: the op is dropped, with no done pulse
    start = 1'b1; alu_op = 4'd8; operand_a = 8'd7; operand_b = 8'd9;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    repeat (3) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    chk("mulrst.res", result, 0);
    chk("mulrst.flags", flags, 0);
    chk("mulrst.busy", busy, 0);
    @(negedge clock);
    reset = 1'b1;
    begin
      int dc;
      dc = 0;
      for (int c = 0; c < 12; c++) begin
        @(negedge clock);
        if (done || busy) dc++;
      end
      chk("mulrst.no_done", dc, 0);
    end
    single(4'd6, 8'h81, 8'h00, 8'h02, 4'b0010, 1'b0, "shl_after_mulrst");
    start = 1'b0;
    @(negedge clock);
`else
    // Without the multiplier, opcode 8 takes the illegal path and the flags keep {0,0,1,0}
    single(4'd8, 8'd13, 8'd11, 8'h00, 4'b0010, 1'b1, "op8_illegal");
    start = 1'b0;
    @(negedge clock);
    chk("op8.done_once", done, 0);
    chk("op8.ill_once", illegal_op, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
